icache_miss_refill_ctrl: RTL and testbench
==========================================

Name: icache_miss_refill_ctrl

Overview:
Miss/refill engine on the far side of the icache tag lookup. It accepts one tag-miss at a time, carrying the line address, the victim way chosen by LRU and a prefetch flag. It issues a line-aligned read downstream, collects the refill beats into a line buffer, and writes the full line into the data array. It then pulses a completion toward the fetch pipeline, and holds `stall` high to the tag controller while a refill is outstanding.

Parameters:
ADDR_WIDTH, 32, physical address width
INDEX_WIDTH, 6, set index width (address bits [OFFSET_WIDTH+INDEX_WIDTH-1:OFFSET_WIDTH])
OFFSET_WIDTH, 6, line offset width (64 B line)
BUS_WIDTH, 128, downstream response data width
LINE_WIDTH, 512, cache line width; BEATS = LINE_WIDTH/BUS_WIDTH = 4
WAY_NUM, 2, ways; way select width = $clog2(WAY_NUM)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
miss_vld  in  1  miss request valid
miss_rdy  out  1  engine can accept a miss
miss_addr  in  ADDR_WIDTH  miss address (any offset)
miss_way  in  $clog2(WAY_NUM)  victim way
miss_prefetch  in  1  miss originated from prefetch
dn_req_vld  out  1  downstream read request valid
dn_req_rdy  in  1  downstream accepts request
dn_req_addr  out  ADDR_WIDTH  line-aligned read address
dn_rsp_vld  in  1  refill beat valid
dn_rsp_rdy  out  1  engine accepts beat
dn_rsp_data  in  BUS_WIDTH  refill beat data
dn_rsp_last  in  1  final beat marker
dn_rsp_err  in  1  beat carries bus error
data_wr_en  out  1  data array line write strobe
data_wr_way  out  $clog2(WAY_NUM)  way to write
data_wr_index  out  INDEX_WIDTH  set to write
data_wr_data  out  LINE_WIDTH  assembled line
refill_done_vld  out  1  one-cycle completion pulse
refill_addr  out  ADDR_WIDTH  line-aligned address of completed refill
refill_err  out  1  completion carries error
refill_prefetch  out  1  completed refill was a prefetch
stall  out  1  refill in progress (to tag controller)

Behaviour:
- FSM states: IDLE, REQ, DATA, WRITE.
- Reset: synchronous, takes priority over all other events. Next edge: state=IDLE; all valid/strobe outputs 0; line buffer, beat counter, error flag, captured addr/way/prefetch all 0. Reset mid-refill abandons the transfer, with no write and no done pulse. Beats that arrive after reset while IDLE are not accepted (dn_rsp_rdy=0).
- miss_rdy = (state==IDLE). stall = (state!=IDLE), combinational from state.
- IDLE: on miss_vld&&miss_rdy:
  - capture miss_addr with offset bits zeroed, plus miss_way and miss_prefetch;
  - clear buffer, counter and err;
  - go to REQ.
- REQ: dn_req_vld=1 and dn_req_addr=captured aligned address, both held stable until dn_req_rdy. Request appears the cycle after miss acceptance. On dn_req_vld&&dn_req_rdy go to DATA.
- DATA: dn_rsp_rdy=1. Each accepted beat k (counter 0..BEATS-1) is written to buffer bits [k*BUS_WIDTH +: BUS_WIDTH], and the counter increments; beat 0 is the low-order slice.
  - err flag is set if dn_rsp_err on any beat.
  - err flag is set if dn_rsp_last arrives with counter != BEATS-1 (early last). The transfer ends on that beat.
  - err flag is set if counter == BEATS-1 and dn_rsp_last=0 (missing last). The transfer still ends after BEATS beats.
  - On the terminating beat go to WRITE.
  - dn_rsp_rdy=0 in every state other than DATA.
- WRITE (exactly one cycle):
  - refill_done_vld=1; refill_addr, refill_err and refill_prefetch are driven from captured values.
  - data_wr_en = !err; data_wr_way, data_wr_index (from captured address) and data_wr_data (buffer) are valid this cycle.
  - Next state IDLE.
- Miss-to-write latency with a zero-wait downstream is 1 (REQ) + BEATS (DATA) cycles; data_wr_en asserts in cycle 1+1+BEATS after the acceptance edge.
- A new miss is accepted no earlier than the cycle after WRITE; there is no overlap and a single outstanding refill.
- data_wr_way/index/data and refill_addr/err/prefetch hold their captured/buffer values outside WRITE. They are qualified only by their strobes.
- Backpressure: stalls of any length on dn_req_rdy or gaps in dn_rsp_vld only extend REQ or DATA; no timeout.

Test Plan:
- Basic refill: miss_addr=0x0000_1A5C, way=1, prefetch=0; dn_req_rdy=1; 4 beats 0x…0 to 0x…3 with last on beat 3. Required: dn_req_addr=0x0000_1A40; data_wr_en one cycle with index=0x29, way=1, data={beat3,beat2,beat1,beat0}; refill_done_vld same cycle with refill_err=0; stall high from the cycle after acceptance through WRITE.
- Backpressure: dn_req_rdy low 5 cycles, 2-cycle gaps between beats. Required: dn_req_addr stable while waiting; line assembled identically to the basic case; miss_rdy stays 0 until after WRITE.
- Bus error: dn_rsp_err=1 on beat 2. Required: all 4 beats consumed; data_wr_en=0; refill_done_vld=1 with refill_err=1.
- Early last: dn_rsp_last on beat 1. Required: WRITE next cycle; refill_err=1; no data write; the next miss is accepted normally.
- Missing last: 4 beats with last=0. Required: ends after beat 3; refill_err=1; a fifth offered beat is not accepted (dn_rsp_rdy=0).
- Reset mid-DATA: assert rst after beat 1 for one cycle. Required: state IDLE, miss_rdy=1, stall=0, no data_wr_en or refill_done_vld. A following miss with way=0, prefetch=1 completes with refill_prefetch=1.

Source files
------------

// File: rtl/icache_miss_refill_ctrl.sv
// rtl/icache_miss_refill_ctrl.sv - icache miss/refill engine: one outstanding line refill
//
// Purpose:
//   Accepts a single tag miss, issues a line-aligned downstream read, gathers
//   BEATS response beats into a line buffer and writes the line into the data
//   array. A one-cycle completion pulse reports the refill to the fetch pipe.
//   stall is held to the tag controller for the whole refill.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   miss_vld/miss_rdy           miss handshake; miss_addr, miss_way, miss_prefetch
//   dn_req_vld/dn_req_rdy       downstream read request; dn_req_addr (line aligned)
//   dn_rsp_vld/dn_rsp_rdy       refill beats; dn_rsp_data, dn_rsp_last, dn_rsp_err
//   data_wr_*                   data array line write (way, index, full line)
//   refill_done_vld             completion pulse; refill_addr/err/prefetch
//   stall                       refill in progress

module icache_miss_refill_ctrl #(
  parameter int ADDR_WIDTH   = 32,
  parameter int INDEX_WIDTH  = 6,
  parameter int OFFSET_WIDTH = 6,
  parameter int BUS_WIDTH    = 128,
  parameter int LINE_WIDTH   = 512,
  parameter int WAY_NUM      = 2,
  localparam int WAY_W       = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   miss_vld,
  output logic                   miss_rdy,
  input  logic [ADDR_WIDTH-1:0]  miss_addr,
  input  logic [WAY_W-1:0]       miss_way,
  input  logic                   miss_prefetch,
  output logic                   dn_req_vld,
  input  logic                   dn_req_rdy,
  output logic [ADDR_WIDTH-1:0]  dn_req_addr,
  input  logic                   dn_rsp_vld,
  output logic                   dn_rsp_rdy,
  input  logic [BUS_WIDTH-1:0]   dn_rsp_data,
  input  logic                   dn_rsp_last,
  input  logic                   dn_rsp_err,
  output logic                   data_wr_en,
  output logic [WAY_W-1:0]       data_wr_way,
  output logic [INDEX_WIDTH-1:0] data_wr_index,
  output logic [LINE_WIDTH-1:0]  data_wr_data,
  output logic                   refill_done_vld,
  output logic [ADDR_WIDTH-1:0]  refill_addr,
  output logic                   refill_err,
  output logic                   refill_prefetch,
  output logic                   stall
);

  localparam int BEATS = LINE_WIDTH / BUS_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK =
    {{(ADDR_WIDTH-OFFSET_WIDTH){1'b1}}, {OFFSET_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DATA,
    S_WRITE
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WAY_W-1:0]      r_way;
  logic                  r_prefetch;
  logic [LINE_WIDTH-1:0] r_buf;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_err;

  logic w_cnt_last;
  logic w_beat_end;

  assign w_cnt_last = (r_cnt == LAST_CNT);
  // A beat ends the transfer either on its own last marker (possibly early)
  // or because the buffer is full, whichever comes first.
  assign w_beat_end = dn_rsp_last || w_cnt_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_way      <= '0;
      r_prefetch <= 1'b0;
      r_buf      <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (miss_vld) begin
            // Masking rather than slicing keeps the full captured address
            // available for refill_addr with its offset already zero.
            r_addr     <= miss_addr & OFFSET_MASK;
            r_way      <= miss_way;
            r_prefetch <= miss_prefetch;
            r_buf      <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (dn_req_rdy) begin
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (dn_rsp_vld) begin
            for (int k = 0; k < BEATS; k++) begin
              if (r_cnt == CNT_W'(k)) begin
                r_buf[k*BUS_WIDTH +: BUS_WIDTH] <= dn_rsp_data;
              end
            end
            r_cnt <= r_cnt + CNT_W'(1);
            // Bus error, early last and missing last all poison the line.
            r_err <= r_err | dn_rsp_err
                           | (dn_rsp_last && !w_cnt_last)
                           | (w_cnt_last && !dn_rsp_last);
            if (w_beat_end) begin
              r_state <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Handshake and strobe outputs decode the state register directly, so they
  // change only on clock edges.
  assign miss_rdy        = (r_state == S_IDLE);
  assign stall           = (r_state != S_IDLE);
  assign dn_req_vld      = (r_state == S_REQ);
  assign dn_req_addr     = r_addr;
  assign dn_rsp_rdy      = (r_state == S_DATA);

  assign data_wr_en      = (r_state == S_WRITE) && !r_err;
  assign data_wr_way     = r_way;
  assign data_wr_index   = r_addr[OFFSET_WIDTH+INDEX_WIDTH-1:OFFSET_WIDTH];
  assign data_wr_data    = r_buf;

  assign refill_done_vld = (r_state == S_WRITE);
  assign refill_addr     = r_addr;
  assign refill_err      = r_err;
  assign refill_prefetch = r_prefetch;

endmodule

// File: tb/tb_icache_miss_refill_ctrl.sv
// tb/tb_icache_miss_refill_ctrl.sv - scoreboard bench for icache_miss_refill_ctrl
module tb_icache_miss_refill_ctrl;

  localparam int AW = 32;
  localparam int IW = 6;
  localparam int OW = 6;
  localparam int BW = 128;
  localparam int LW = 512;
  localparam int NB = LW / BW;

  logic          clk = 1'b0;
  logic          rst;
  logic          miss_vld;
  logic          miss_rdy;
  logic [AW-1:0] miss_addr;
  logic          miss_way;
  logic          miss_prefetch;
  logic          dn_req_vld;
  logic          dn_req_rdy;
  logic [AW-1:0] dn_req_addr;
  logic          dn_rsp_vld;
  logic          dn_rsp_rdy;
  logic [BW-1:0] dn_rsp_data;
  logic          dn_rsp_last;
  logic          dn_rsp_err;
  logic          data_wr_en;
  logic          data_wr_way;
  logic [IW-1:0] data_wr_index;
  logic [LW-1:0] data_wr_data;
  logic          refill_done_vld;
  logic [AW-1:0] refill_addr;
  logic          refill_err;
  logic          refill_prefetch;
  logic          stall;

  icache_miss_refill_ctrl #(
    .ADDR_WIDTH(AW), .INDEX_WIDTH(IW), .OFFSET_WIDTH(OW),
    .BUS_WIDTH(BW), .LINE_WIDTH(LW), .WAY_NUM(2)
  ) dut (
    .clk(clk), .rst(rst),
    .miss_vld(miss_vld), .miss_rdy(miss_rdy), .miss_addr(miss_addr),
    .miss_way(miss_way), .miss_prefetch(miss_prefetch),
    .dn_req_vld(dn_req_vld), .dn_req_rdy(dn_req_rdy), .dn_req_addr(dn_req_addr),
    .dn_rsp_vld(dn_rsp_vld), .dn_rsp_rdy(dn_rsp_rdy), .dn_rsp_data(dn_rsp_data),
    .dn_rsp_last(dn_rsp_last), .dn_rsp_err(dn_rsp_err),
    .data_wr_en(data_wr_en), .data_wr_way(data_wr_way),
    .data_wr_index(data_wr_index), .data_wr_data(data_wr_data),
    .refill_done_vld(refill_done_vld), .refill_addr(refill_addr),
    .refill_err(refill_err), .refill_prefetch(refill_prefetch),
    .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          way;
    logic [IW-1:0] idx;
    logic [LW-1:0] data;
    logic          err;
    logic          pf;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_mis = 0;
  int   n_exp = 0;
  int   n_done = 0;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Completion monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (data_wr_en) chk("wr_en_with_done", LW'(refill_done_vld), LW'(1));
    if (refill_done_vld) begin
      n_done++;
      chk("sb_has_entry", LW'(sb_q.size() != 0), LW'(1));
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        chk("refill_addr", LW'(refill_addr), LW'(e.addr));
        chk("refill_err", LW'(refill_err), LW'(e.err));
        chk("refill_prefetch", LW'(refill_prefetch), LW'(e.pf));
        chk("data_wr_en", LW'(data_wr_en), LW'(!e.err));
        chk("data_wr_way", LW'(data_wr_way), LW'(e.way));
        chk("data_wr_index", LW'(data_wr_index), LW'(e.idx));
        chk("data_wr_data", data_wr_data, e.data);
      end
    end
  end

  // One refill transaction. last_at<0 means no last marker; err_at<0 means
  // no bus error; abort_after>=0 pulses reset right after that beat.
  task automatic run_refill(input logic [AW-1:0] addr, input logic way, input logic pf,
                            input int req_wait, input int gap, input int last_at,
                            input int err_at, input int abort_after);
    logic [BW-1:0] beat [NB];
    logic [LW-1:0] line;
    logic [AW-1:0] aligned;
    int            nb;
    exp_t          e;
    aligned = {addr[AW-1:OW], {OW{1'b0}}};
    nb   = (last_at >= 0 && last_at < NB - 1) ? last_at + 1 : NB;
    line = '0;
    for (int k = 0; k < nb; k++) begin
      beat[k] = {$urandom, $urandom, $urandom, $urandom};
      beat[k][3:0] = 4'(k);
      line[k*BW +: BW] = beat[k];
    end
    if (abort_after < 0) begin
      e.addr = aligned;
      e.way  = way;
      e.idx  = aligned[OW+IW-1:OW];
      e.data = line;
      e.err  = ((err_at >= 0) && (err_at < nb)) || (last_at != NB - 1);
      e.pf   = pf;
      sb_q.push_back(e);
      n_exp++;
    end

    @(posedge clk); #1;
    miss_vld = 1'b1; miss_addr = addr; miss_way = way; miss_prefetch = pf;
    chk("miss_rdy_idle", LW'(miss_rdy), LW'(1));
    @(posedge clk); #1;
    miss_vld = 1'b0;
    chk("stall_req", LW'(stall), LW'(1));
    chk("dn_req_vld", LW'(dn_req_vld), LW'(1));
    chk("dn_req_addr", LW'(dn_req_addr), LW'(aligned));
    chk("miss_rdy_busy", LW'(miss_rdy), LW'(0));
    for (int w = 0; w < req_wait; w++) begin
      @(posedge clk); #1;
      chk("dn_req_vld_hold", LW'(dn_req_vld), LW'(1));
      chk("dn_req_addr_hold", LW'(dn_req_addr), LW'(aligned));
      chk("miss_rdy_wait", LW'(miss_rdy), LW'(0));
    end
    dn_req_rdy = 1'b1;
    @(posedge clk); #1;
    dn_req_rdy = 1'b0;
    chk("dn_req_vld_drop", LW'(dn_req_vld), LW'(0));

    for (int k = 0; k < nb; k++) begin
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        chk("stall_gap", LW'(stall), LW'(1));
        chk("miss_rdy_gap", LW'(miss_rdy), LW'(0));
      end
      dn_rsp_vld  = 1'b1;
      dn_rsp_data = beat[k];
      dn_rsp_last = (k == last_at);
      dn_rsp_err  = (k == err_at);
      chk("dn_rsp_rdy_data", LW'(dn_rsp_rdy), LW'(1));
      @(posedge clk); #1;
      dn_rsp_vld = 1'b0; dn_rsp_last = 1'b0; dn_rsp_err = 1'b0;
      if (k == abort_after) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_miss_rdy", LW'(miss_rdy), LW'(1));
        chk("abort_stall", LW'(stall), LW'(0));
        chk("abort_wr_en", LW'(data_wr_en), LW'(0));
        chk("abort_done", LW'(refill_done_vld), LW'(0));
        dn_rsp_vld = 1'b1;
        chk("abort_rsp_rdy", LW'(dn_rsp_rdy), LW'(0));
        @(posedge clk); #1;
        dn_rsp_vld = 1'b0;
        return;
      end
    end

    chk("done_latency", LW'(refill_done_vld), LW'(1));
    chk("stall_write", LW'(stall), LW'(1));
    chk("miss_rdy_write", LW'(miss_rdy), LW'(0));
    if (last_at < 0) begin
      dn_rsp_vld  = 1'b1;
      dn_rsp_data = '1;
      chk("extra_beat_rdy_write", LW'(dn_rsp_rdy), LW'(0));
    end
    @(posedge clk); #1;
    if (last_at < 0) chk("extra_beat_rdy_idle", LW'(dn_rsp_rdy), LW'(0));
    dn_rsp_vld = 1'b0;
    chk("miss_rdy_after", LW'(miss_rdy), LW'(1));
    chk("stall_after", LW'(stall), LW'(0));
    chk("done_single", LW'(refill_done_vld), LW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    miss_vld = 1'b0; miss_addr = '0; miss_way = 1'b0; miss_prefetch = 1'b0;
    dn_req_rdy = 1'b0;
    dn_rsp_vld = 1'b0; dn_rsp_data = '0; dn_rsp_last = 1'b0; dn_rsp_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_miss_rdy", LW'(miss_rdy), LW'(1));
    chk("rst_stall", LW'(stall), LW'(0));
    chk("rst_req_vld", LW'(dn_req_vld), LW'(0));
    chk("rst_wr_en", LW'(data_wr_en), LW'(0));
    chk("rst_done", LW'(refill_done_vld), LW'(0));
    chk("rst_wr_data", data_wr_data, '0);
    chk("rst_refill_addr", LW'(refill_addr), LW'(0));
    rst = 1'b0;
    dn_rsp_vld = 1'b1;
    chk("idle_rsp_rdy", LW'(dn_rsp_rdy), LW'(0));
    @(posedge clk); #1;
    dn_rsp_vld = 1'b0;

    run_refill(32'h0000_1A5C, 1'b1, 1'b0, 0, 0, 3, -1, -1);  // basic
    run_refill(32'h0000_1A5C, 1'b1, 1'b0, 5, 2, 3, -1, -1);  // backpressure
    run_refill(32'h0012_34C7, 1'b0, 1'b0, 0, 0, 3, 2, -1);   // bus error on beat 2
    run_refill(32'h0000_0FFF, 1'b1, 1'b1, 0, 1, 1, -1, -1);  // early last
    run_refill(32'h0000_2040, 1'b0, 1'b0, 1, 0, 3, -1, -1);  // normal after early last
    run_refill(32'hFFFF_FFC1, 1'b1, 1'b0, 0, 0, -1, -1, -1); // missing last
    run_refill(32'h0000_3000, 1'b1, 1'b0, 0, 0, 3, -1, 1);   // reset mid-DATA
    run_refill(32'h0000_3008, 1'b0, 1'b1, 0, 0, 3, -1, -1);  // after reset, prefetch
    for (int i = 0; i < 4; i++) begin
      run_refill($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3), $urandom_range(0, 2), 3, -1, -1);
    end

    repeat (2) @(posedge clk);
    #1;
    chk("done_count", LW'(n_done), LW'(n_exp));
    chk("sb_drained", LW'(sb_q.size()), LW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
